// File: rtl/weight_streamer.sv
// weight_streamer: streams a window of BRAM words out as a valid/ready stream.
// The BRAM has a one-cycle read latency, so each issued read becomes a write into
// a small 4-entry FIFO one cycle later. The FIFO is what drives the output stream.
// Optional feature macro: WEIGHT_STREAMER_REPEAT_EN streams the window
// repeat_count+1 times back-to-back.
module weight_streamer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
`ifdef WEIGHT_STREAMER_REPEAT_EN
  input  logic [7:0]            repeat_count,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  mem_read_enable,
  output logic [ADDR_WIDTH-1:0] mem_read_address,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                state;
  state_t                next_state;
  logic [ADDR_WIDTH-1:0] base_reg;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   len_reg;
  logic [ADDR_WIDTH:0]   reads_left;
  logic [ADDR_WIDTH:0]   popped;
  logic [7:0]            repeat_in;
  logic [7:0]            issue_passes;
  logic [7:0]            pop_passes;
  logic                  pending;
  logic [DATA_WIDTH-1:0] fifo_mem [4];
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [2:0]            fifo_count;
  logic                  done_reg;
  logic                  accept;
  logic                  zero_cmd;
  logic                  issue;
  logic                  pop;
  logic                  final_word;
  logic                  last_pop;

`ifdef WEIGHT_STREAMER_REPEAT_EN
  assign repeat_in = repeat_count;
`else
  assign repeat_in = 8'd0;
`endif

  // Pass counters and the popped-word counter together identify the very last word
  // of the whole command, which is what ends the command.
  assign out_valid        = (fifo_count != 3'd0);
  assign out_data         = fifo_mem[rd_ptr];
  assign pop              = out_valid & out_ready;
  assign final_word       = (popped == (len_reg - CNT_ONE)) && (pop_passes == 8'd0);
  assign out_last         = out_valid & final_word;
  assign last_pop         = pop & final_word;
  assign busy             = (state != IDLE);
  assign done             = done_reg;
  assign mem_read_enable  = issue;
  assign mem_read_address = addr;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic. A read is issued only while buffered plus in-flight words
  // leave room in the FIFO, so the returning word always has a slot.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    zero_cmd   = 1'b0;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            accept     = 1'b1;
            next_state = FETCH;
          end else begin
            zero_cmd = 1'b1;
          end
        end
      end
      FETCH: begin
        if ((fifo_count + {2'b00, pending}) < 3'd4) begin
          issue = 1'b1;
          if ((reads_left == CNT_ONE) && (issue_passes == 8'd0)) next_state = FLUSH;
        end
      end
      FLUSH: begin
        if (last_pop) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Command capture, read-address sequencing, return-path FIFO and pop accounting.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      base_reg     <= '0;
      addr         <= '0;
      len_reg      <= '0;
      reads_left   <= '0;
      popped       <= '0;
      issue_passes <= '0;
      pop_passes   <= '0;
      pending      <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      done_reg     <= 1'b0;
      for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
    end else begin
      done_reg <= last_pop | zero_cmd;
      pending  <= issue;

      if (accept) begin
        base_reg     <= base_addr;
        addr         <= base_addr;
        len_reg      <= length;
        reads_left   <= length;
        issue_passes <= repeat_in;
        pop_passes   <= repeat_in;
        popped       <= '0;
      end

      if (issue) begin
        if ((reads_left == CNT_ONE) && (issue_passes != 8'd0)) begin
          addr         <= base_reg;
          reads_left   <= len_reg;
          issue_passes <= issue_passes - 8'd1;
        end else begin
          addr       <= addr + ADDR_ONE;
          reads_left <= reads_left - CNT_ONE;
        end
      end

      if (pending) begin
        fifo_mem[wr_ptr] <= mem_read_data;
        wr_ptr           <= wr_ptr + 2'd1;
      end

      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
        if (popped == (len_reg - CNT_ONE)) begin
          popped <= '0;
          if (pop_passes != 8'd0) pop_passes <= pop_passes - 8'd1;
        end else begin
          popped <= popped + CNT_ONE;
        end
      end

      fifo_count <= fifo_count + {2'b00, pending} - {2'b00, pop};
    end
  end

endmodule

// File: tb/tb_weight_streamer.sv
// Testbench for weight_streamer: a BRAM model holding ram[i]=i*3, a consumer with
// selectable ready behaviour, a passive monitor, and a reference model that lists
// the expected address/word/last sequence for each command.
module tb_weight_streamer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [8:0]  length = '0;
`ifdef WEIGHT_STREAMER_REPEAT_EN
  logic [7:0]  repeat_count_v = '0;
`endif
  logic        busy;
  logic        done;
  logic        mem_read_enable;
  logic [7:0]  mem_read_address;
  logic [31:0] mem_read_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_last;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_mode = 0;

  // Monitor state
  logic [31:0] got_data[$];
  bit          got_last[$];
  int          got_cyc[$];
  logic [7:0]  got_addr[$];
  int issued = 0, popped = 0, ovf_err = 0, stab_err = 0;
  int done_cnt = 0, busy_cnt = 0, valid_cnt = 0;
  bit prev_stall = 0;
  logic [31:0] prev_data = '0;

  // Reference model output
  logic [31:0] exp_data[$];
  bit          exp_last[$];
  logic [7:0]  exp_addr[$];

  weight_streamer #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .base_addr(base_addr),
    .length(length),
`ifdef WEIGHT_STREAMER_REPEAT_EN
    .repeat_count(repeat_count_v),
`endif
    .busy(busy),
    .done(done),
    .mem_read_enable(mem_read_enable),
    .mem_read_address(mem_read_address),
    .mem_read_data(mem_read_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last)
  );

  always #5 clock = ~clock;

  // Cycle counter
  always @(posedge clock) cyc <= cyc + 1;

  // BRAM model: one-cycle latency, drives 0 when no read was enabled
  always @(posedge clock) mem_read_data <= mem_read_enable ? (32'(mem_read_address) * 32'd3) : 32'd0;

  // Consumer ready: 0 = always ready, 1 = ready ~30% of cycles, 2 = never ready
  always @(posedge clock) begin
    #2;
    if (ready_mode == 0)      out_ready = 1'b1;
    else if (ready_mode == 1) out_ready = ($urandom_range(0, 99) < 30);
    else                      out_ready = 1'b0;
  end

  // Passive monitor sampling on the falling edge
  always @(negedge clock) begin
    if (reset) begin
      issued = 0;
      popped = 0;
      prev_stall = 0;
    end else begin
      if (mem_read_enable) begin
        got_addr.push_back(mem_read_address);
        if (issued - popped >= 4) ovf_err++;
      end
      if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data)) stab_err++;
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
        got_cyc.push_back(cyc);
      end
      if (done)      done_cnt++;
      if (busy)      busy_cnt++;
      if (out_valid) valid_cnt++;
      if (mem_read_enable) issued++;
      if (out_valid && out_ready) popped++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic clear_monitor();
    got_data.delete(); got_last.delete(); got_cyc.delete(); got_addr.delete();
    ovf_err = 0; stab_err = 0; done_cnt = 0; busy_cnt = 0; valid_cnt = 0;
  endtask

  task automatic clear_model();
    exp_data.delete(); exp_last.delete(); exp_addr.delete();
  endtask

  // Window of len words from base, wrapping at 256, repeated rep+1 times
  task automatic build_model(input int base, input int len, input int rep);
    for (int p = 0; p <= rep; p++) begin
      for (int i = 0; i < len; i++) begin
        int a;
        a = (base + i) % 256;
        exp_addr.push_back(8'(a));
        exp_data.push_back(32'(a * 3));
        exp_last.push_back((p == rep) && (i == len - 1));
      end
    end
  endtask

  task automatic drive_start(input int base, input int len, input int rep);
    base_addr = 8'(base);
    length    = 9'(len);
`ifdef WEIGHT_STREAMER_REPEAT_EN
    repeat_count_v = 8'(rep);
`else
    if (rep != 0) $display("[TB] repeat ignored in this build");
`endif
    start = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({busy, done, mem_read_enable, mem_read_address, out_valid, out_data, out_last} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got busy=%0b done=%0b en=%0b addr=%h valid=%0b data=%h last=%0b, want all 0",
               busy, done, mem_read_enable, mem_read_address, out_valid, out_data, out_last);
    end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_stream(input string name, input int base, input int len, input int rep,
                             input int mode, input bit timed);
    int s, d, bound, n;
    clear_model();
    build_model(base, len, rep);
    ready_mode = mode;
    @(posedge clock); #1;
    clear_monitor();
    drive_start(base, len, rep);
    s = cyc;
    @(posedge clock); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || mem_read_enable !== 1'b1 || mem_read_address !== 8'(base)) begin
      errors++;
      $display("[TB] FAIL %s first_read: got busy=%0b en=%0b addr=%h, want busy=1 en=1 addr=%h",
               name, busy, mem_read_enable, mem_read_address, 8'(base));
    end
    bound = len * (rep + 1) * 20 + 50;
    d = -1;
    for (int i = 0; i < bound; i++) begin
      @(posedge clock); #1;
      if (done === 1'b1) begin d = cyc; break; end
    end
    checks++;
    if (d < 0) begin
      errors++;
      $display("[TB] FAIL %s done_timeout: got no done within %0d cycles, want done", name, bound);
      return;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s busy_at_done: got %0b want 0", name, busy);
    end
    repeat (3) @(posedge clock);
    #1;
    n = exp_data.size();
    checks++;
    if (got_data.size() != n) begin
      errors++;
      $display("[TB] FAIL %s word_count: got %0d want %0d", name, got_data.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        checks++;
        if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
          errors++;
          $display("[TB] FAIL %s word[%0d]: got data=%h last=%0b want data=%h last=%0b",
                   name, i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
        end
      end
      checks++;
      if (d != got_cyc[n-1] + 1) begin
        errors++;
        $display("[TB] FAIL %s done_cycle: got %0d want %0d", name, d, got_cyc[n-1] + 1);
      end
      if (timed) begin
        checks++;
        if (got_cyc[0] != s + 3 || got_cyc[n-1] != s + 2 + n) begin
          errors++;
          $display("[TB] FAIL %s stream_timing: got first=%0d last=%0d want first=%0d last=%0d",
                   name, got_cyc[0] - s, got_cyc[n-1] - s, 3, 2 + n);
        end
      end
    end
    checks++;
    if (got_addr.size() != exp_addr.size()) begin
      errors++;
      $display("[TB] FAIL %s read_count: got %0d want %0d", name, got_addr.size(), exp_addr.size());
    end else begin
      for (int i = 0; i < exp_addr.size(); i++) begin
        checks++;
        if (got_addr[i] !== exp_addr[i]) begin
          errors++;
          $display("[TB] FAIL %s addr[%0d]: got %h want %h", name, i, got_addr[i], exp_addr[i]);
        end
      end
    end
    checks++;
    if (ovf_err != 0 || stab_err != 0 || done_cnt != 1) begin
      errors++;
      $display("[TB] FAIL %s flow: got overfill=%0d unstable=%0d done_pulses=%0d want 0 0 1",
               name, ovf_err, stab_err, done_cnt);
    end
  endtask

  task automatic test_zero_length();
    ready_mode = 0;
    @(posedge clock); #1;
    clear_monitor();
    drive_start(8'h42, 0, 0);
    @(posedge clock); #1;
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_len_done: got done=%0b busy=%0b want done=1 busy=0", done, busy);
    end
    repeat (4) @(posedge clock);
    #1;
    checks++;
    if (done_cnt != 1 || busy_cnt != 0 || valid_cnt != 0 || got_addr.size() != 0) begin
      errors++;
      $display("[TB] FAIL zero_len_quiet: got done=%0d busy=%0d valid=%0d reads=%0d want 1 0 0 0",
               done_cnt, busy_cnt, valid_cnt, got_addr.size());
    end
  endtask

  task automatic test_mid_reset();
    ready_mode = 2;
    @(posedge clock); #1;
    clear_monitor();
    drive_start(8'h20, 16, 0);
    @(posedge clock); #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h60) begin
      errors++;
      $display("[TB] FAIL pre_reset_head: got valid=%0b data=%h want valid=1 data=00000060", out_valid, out_data);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, mem_read_enable, mem_read_address, out_valid, out_data, out_last} !== '0) begin
      errors++;
      $display("[TB] FAIL mid_reset_outputs: got busy=%0b done=%0b en=%0b addr=%h valid=%0b data=%h last=%0b, want all 0",
               busy, done, mem_read_enable, mem_read_address, out_valid, out_data, out_last);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    test_stream("after_reset", 8'h80, 5, 0, 0, 1);
  endtask

  task automatic test_back_to_back();
    int d;
    clear_model();
    build_model(5, 3, 0);
    build_model(8'h40, 2, 0);
    ready_mode = 0;
    @(posedge clock); #1;
    clear_monitor();
    drive_start(5, 3, 0);
    @(posedge clock); #1;
    start = 1'b0;
    d = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (done === 1'b1) begin d = cyc; break; end
    end
    checks++;
    if (d < 0) begin
      errors++;
      $display("[TB] FAIL b2b_first_done: got no done want done");
      return;
    end
    drive_start(8'h40, 2, 0);
    @(posedge clock); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || mem_read_enable !== 1'b1 || mem_read_address !== 8'h40) begin
      errors++;
      $display("[TB] FAIL b2b_accept: got busy=%0b en=%0b addr=%h want busy=1 en=1 addr=40",
               busy, mem_read_enable, mem_read_address);
    end
    repeat (10) @(posedge clock);
    #1;
    checks++;
    if (got_data.size() != exp_data.size() || done_cnt != 2) begin
      errors++;
      $display("[TB] FAIL b2b_count: got words=%0d dones=%0d want words=%0d dones=2",
               got_data.size(), done_cnt, exp_data.size());
    end else begin
      for (int i = 0; i < exp_data.size(); i++) begin
        checks++;
        if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
          errors++;
          $display("[TB] FAIL b2b_word[%0d]: got data=%h last=%0b want data=%h last=%0b",
                   i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 5; k++) begin
      int base, len, rep, mode;
      base = $urandom_range(0, 255);
      len  = $urandom_range(1, 20);
      mode = $urandom_range(0, 1);
`ifdef WEIGHT_STREAMER_REPEAT_EN
      rep = $urandom_range(0, 2);
`else
      rep = 0;
`endif
      test_stream("random", base, len, rep, mode, mode == 0);
    end
  endtask

  initial begin
    test_reset();
    test_stream("basic", 8'h10, 4, 0, 0, 1);
    test_stream("slow_ready", 8'h10, 4, 0, 1, 0);
    test_stream("wrap", 8'hFE, 4, 0, 0, 1);
    test_zero_length();
    test_stream("full_window", 8'h33, 256, 0, 0, 1);
    test_mid_reset();
    test_back_to_back();
`ifdef WEIGHT_STREAMER_REPEAT_EN
    test_stream("repeat", 0, 3, 1, 0, 1);
    test_stream("repeat_slow", 8'hFF, 2, 2, 1, 0);
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL watchdog: got simulation still running want finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/weight_streamer.md
# weight_streamer

Read-side initiator for the single-port-pair BRAM weight store. On a `start` command it issues sequential reads over an address window, absorbs the BRAM's one-cycle read latency, and presents the words as a valid/ready stream with a last marker to the layer datapath. It sits between a weight BRAM's read port and the neuron/MAC array, and is reused for every multiplexed layer pass.

## Interface
- DATA_WIDTH, 32, weight word width; must match the BRAM.
- ADDR_WIDTH, 8, BRAM address width; depth = 2^ADDR_WIDTH.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first address of window; captured with `start`.
- length  in  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH; captured with `start`.
- busy  out  1  high from cycle after accepted `start` until `done`.
- done  out  1  one-cycle pulse at end of command.
- mem_read_enable  out  1  to BRAM readEnable.
- mem_read_address  out  ADDR_WIDTH  to BRAM readAddress.
- mem_read_data  in  DATA_WIDTH  from BRAM readData; valid the cycle after an enabled read.
- out_valid  out  1  stream word valid.
- out_ready  in  1  consumer accept.
- out_data  out  DATA_WIDTH  stream word.
- out_last  out  1  high with the final word of the command.

## Operation
- States: IDLE, FETCH, FLUSH. IDLE→FETCH on `start` with length>0. IDLE→IDLE with `done` pulse next cycle on `start` with length=0; no reads, no output. FETCH→FLUSH when last read issued. FLUSH→IDLE when final word handshaked (out_valid & out_ready & out_last).
- `start` outside IDLE is ignored; inputs not re-sampled.
- Read issue (FETCH only): mem_read_enable=1 iff fifo_count + pending < 4, where pending = read issued previous cycle. mem_read_enable low otherwise; address held.
- mem_read_address starts at base_addr, increments per issued read modulo 2^ADDR_WIDTH (0xFF→0x00 wraps silently).
- Return path: a 1-bit `pending` register marks that mem_read_data is valid this cycle; it is written into a 4-entry output FIFO at the end of that cycle. mem_read_data is never sampled when pending=0 (the BRAM drives 0 then).
- Output: out_valid = FIFO non-empty; out_data = FIFO head; pop on out_valid & out_ready. out_data/out_valid stable while out_valid & !out_ready.
- Word counter counts popped words; out_last = out_valid & (popped == total-1).
- Reset (any time, including mid-stream): state IDLE; FIFO, pending, counters cleared; all outputs 0. In-flight BRAM data after reset is discarded.

## Timing
- Reset values: busy 0, done 0, mem_read_enable 0, mem_read_address 0, out_valid 0, out_data 0, out_last 0.
- `start` in cycle 0 → busy=1 and first read in cycle 1 → data on mem_read_data cycle 2 → out_valid=1 in cycle 3.
- With out_ready held high: one word per cycle sustained; FIFO never exceeds 2 entries.
- Final handshake in cycle k → done=1, busy=0 in cycle k+1; a new `start` is accepted in cycle k+1.
- FIFO full with out_ready low: issue stalls within 0 cycles; no word dropped or duplicated.

## Configuration
- WEIGHT_STREAMER_REPEAT_EN defined: adds input `repeat_count` [7:0], captured with `start`; window is streamed repeat_count+1 times back-to-back (address reloads base_addr with no bubble); out_last only on final word of final pass; done after final pass. length=0 still finishes immediately.
- Undefined: port absent; exactly one pass.

## Test plan
- BRAM model ram[i]=i*3; start base=0x10, length=4, out_ready=1 → out_data 0x30,0x33,0x36,0x39 on cycles 3–6, out_last on 0x39, done cycle 7.
- Same command, out_ready pseudo-random 30% → same 4 words in order, no gaps/dups, mem_read_enable never asserted with fifo_count+pending≥4.
- base=0xFE, length=4 → addresses 0xFE,0xFF,0x00,0x01; data 0x2FA,0x2FD,0x000,0x003.
- length=0 → done cycle 1, busy stays 0, out_valid and mem_read_enable never assert; length=256 → all 256 words, last at address base-1.
- reset asserted mid-stream with 2 words buffered → all outputs 0 immediately; next command streams clean data.
- REPEAT_EN, base=0, length=3, repeat_count=1 → 0,3,6,0,3,6, single out_last on final 6.
